// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared width defaults, FSM state type and pointer helper for
// the RAM arbiter (ram_arbiter, ram_arb_if, ram_arb_select).
package ram_arb_pkg;

   localparam int RAM_ARB_ADDR_W = 10;
   localparam int RAM_ARB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } ram_arb_state_t;

   // Round-robin successor of a requester index, wrapping at n.
   function automatic int rr_next(input int idx, input int n);
      return ((idx + 32'sd1) >= n) ? 32'sd0 : (idx + 32'sd1);
   endfunction

endpackage

// File: rtl/ram_arb_if.sv
// ram_arb_if: requester-side req/ack handshake bundle of the RAM arbiter.
// master = requester side, slave = arbiter side.
interface ram_arb_if
   import ram_arb_pkg::*;
#(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = RAM_ARB_ADDR_W,
   parameter int DATA_W = RAM_ARB_DATA_W
) ();

   logic [N_REQ-1:0]             req;
   logic [N_REQ-1:0]             we;
   logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [N_REQ-1:0][DATA_W-1:0] req_wdata;
   logic [N_REQ-1:0]             ack;
   logic [DATA_W-1:0]            rdata;

   modport master (
      output req, we, req_addr, req_wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, req_addr, req_wdata,
      output ack, rdata
   );

endinterface

// File: rtl/ram_arb_select.sv
// ram_arb_select: combinational winner pick among the pending requests.
// RAM_ARB_ROUND_ROBIN_EN defined  -> search starts at ptr (round-robin).
// RAM_ARB_ROUND_ROBIN_EN undefined -> lowest index wins, ptr is ignored.
module ram_arb_select #(
   parameter int N_REQ = 2,
   parameter int IDX_W = 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic [2*N_REQ-1:0] dbl_req_s;
   logic [2*N_REQ-1:0] dbl_gnt_s;
   logic [N_REQ-1:0]   rot_req_s;
   logic [N_REQ-1:0]   rot_gnt_s;

   // Rotate so the pointer slot is bit 0, keep the lowest set bit, rotate back
   always_comb begin
      dbl_req_s = {req, req};
      rot_req_s = N_REQ'(dbl_req_s >> ptr);
      rot_gnt_s = rot_req_s & (~rot_req_s + N_REQ'(1));
      dbl_gnt_s = {rot_gnt_s, rot_gnt_s};
      gnt       = N_REQ'(dbl_gnt_s >> (N_REQ - int'(ptr)));
   end
`else
   logic unused_ptr_s;
   assign unused_ptr_s = ^ptr;

   // Lowest-index pending request wins
   always_comb begin
      gnt = req & (~req + N_REQ'(1));
   end
`endif

   // Encode the one-hot grant into an index
   always_comb begin
      gnt_idx = {IDX_W{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         gnt_idx = gnt_idx | (gnt[i] ? IDX_W'(i) : {IDX_W{1'b0}});
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM among N_REQ requesters. Each grant
// runs IDLE -> ACCESS -> RESP; the RAM controls are only active in ACCESS and
// the completion ack pulses in RESP. The arbiter is the only writer of bus.
// Optional macro RAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (default: fixed priority, lowest index wins).
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = RAM_ARB_ADDR_W,
   parameter int DATA_W = RAM_ARB_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   ram_arb_if.slave          rq,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              RAM_read,
   output logic              RAM_write,
   inout  tri0 [DATA_W-1:0]  bus
);

   localparam int IDX_W = (N_REQ > 2) ? 2 : 1;

   ram_arb_state_t    state_r;
   ram_arb_state_t    state_nxt_s;
   logic [ADDR_W-1:0] ram_addr_r;
   logic [ADDR_W-1:0] ram_addr_nxt_s;
   logic [DATA_W-1:0] wbuf_r;
   logic [DATA_W-1:0] wbuf_nxt_s;
   logic [DATA_W-1:0] rdata_r;
   logic [DATA_W-1:0] rdata_nxt_s;
   logic              we_r;
   logic              we_nxt_s;
   logic [N_REQ-1:0]  gnt_r;
   logic [N_REQ-1:0]  gnt_nxt_s;
   logic [N_REQ-1:0]  ack_r;
   logic [N_REQ-1:0]  ack_nxt_s;
   logic              ram_read_r;
   logic              ram_read_nxt_s;
   logic              ram_write_r;
   logic              ram_write_nxt_s;
   logic [IDX_W-1:0]  ptr_s;
   logic [N_REQ-1:0]  sel_gnt_s;
   logic [IDX_W-1:0]  sel_idx_s;
   logic              any_req_s;

   assign any_req_s = |rq.req;

   ram_arb_select #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_select (
      .req     (rq.req),
      .ptr     (ptr_s),
      .gnt     (sel_gnt_s),
      .gnt_idx (sel_idx_s)
   );

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] ptr_r;
   logic [IDX_W-1:0] ptr_nxt_s;

   // Pointer moves just past the winner on every grant, otherwise holds
   always_comb begin
      if ((state_r == IDLE) && any_req_s) begin
         ptr_nxt_s = IDX_W'(rr_next(32'(sel_idx_s), N_REQ));
      end else begin
         ptr_nxt_s = ptr_r;
      end
   end

   // Round-robin pointer register
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= {IDX_W{1'b0}};
      end else begin
         ptr_r <= ptr_nxt_s;
      end
   end

   assign ptr_s = ptr_r;
`else
   assign ptr_s = {IDX_W{1'b0}};
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state and next values of every registered output
   always_comb begin
      state_nxt_s     = state_r;
      ram_addr_nxt_s  = ram_addr_r;
      wbuf_nxt_s      = wbuf_r;
      rdata_nxt_s     = rdata_r;
      we_nxt_s        = we_r;
      gnt_nxt_s       = gnt_r;
      ack_nxt_s       = {N_REQ{1'b0}};
      ram_read_nxt_s  = 1'b0;
      ram_write_nxt_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               state_nxt_s     = ACCESS;
               ram_addr_nxt_s  = rq.req_addr[sel_idx_s];
               we_nxt_s        = rq.we[sel_idx_s];
               wbuf_nxt_s      = rq.req_wdata[sel_idx_s];
               gnt_nxt_s       = sel_gnt_s;
               ram_read_nxt_s  = rq.we[sel_idx_s];
               ram_write_nxt_s = ~rq.we[sel_idx_s];
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCESS: begin
            state_nxt_s = RESP;
            ack_nxt_s   = gnt_r;
            // RAM drives bus combinationally during a read ACCESS
            if (!we_r) begin
               rdata_nxt_s = bus;
            end else begin
               rdata_nxt_s = rdata_r;
            end
         end
         RESP: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Datapath and output registers; reset clears all of them
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_addr_r  <= {ADDR_W{1'b0}};
         wbuf_r      <= {DATA_W{1'b0}};
         rdata_r     <= {DATA_W{1'b0}};
         we_r        <= 1'b0;
         gnt_r       <= {N_REQ{1'b0}};
         ack_r       <= {N_REQ{1'b0}};
         ram_read_r  <= 1'b0;
         ram_write_r <= 1'b0;
      end else begin
         ram_addr_r  <= ram_addr_nxt_s;
         wbuf_r      <= wbuf_nxt_s;
         rdata_r     <= rdata_nxt_s;
         we_r        <= we_nxt_s;
         gnt_r       <= gnt_nxt_s;
         ack_r       <= ack_nxt_s;
         ram_read_r  <= ram_read_nxt_s;
         ram_write_r <= ram_write_nxt_s;
      end
   end

   assign ram_addr  = ram_addr_r;
   assign RAM_read  = ram_read_r;
   assign RAM_write = ram_write_r;
   assign rq.ack    = ack_r;
   assign rq.rdata  = rdata_r;

   // Only the write ACCESS drives the bus; the tri0 pull-down covers the rest
   assign bus = ram_read_r ? wbuf_r : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter with a behavioural RAM
// and a timing/arbitration reference model. Honours RAM_ARB_ROUND_ROBIN_EN.
module tb_ram_arbiter;

   localparam int N  = 2;
   localparam int AW = 10;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_arb_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) rq ();

   logic [AW-1:0] ram_addr;
   logic          ram_read;
   logic          ram_write;
   tri0 [DW-1:0]  bus;

   ram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .rq        (rq),
      .ram_addr  (ram_addr),
      .RAM_read  (ram_read),
      .RAM_write (ram_write),
      .bus       (bus)
   );

   // Behavioural 1024x32 RAM: combinational read onto bus, clocked write
   logic [DW-1:0] ram_mem [0:1023];
   assign bus = ram_write ? ram_mem[ram_addr] : {DW{1'bz}};
   always @(posedge clk) begin
      if (ram_read) ram_mem[ram_addr] <= bus;
   end

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [DW-1:0] exp_mem [0:1023];
   int            edge_n     = 0;
   int            grant_edge = -100;
   int            free_edge  = 0;
   int            rr_ptr     = 0;
   int            g_idx      = 0;
   logic          g_we       = 1'b0;
   logic [AW-1:0] g_addr     = '0;
   logic [DW-1:0] g_wdata    = '0;
   logic [AW-1:0] exp_addr   = '0;
   logic [DW-1:0] exp_rdata  = '0;
   logic [N-1:0]  exp_ack;
   logic          exp_rd;
   logic          exp_wr;

   logic [N-1:0]  obs_ack;
   logic          obs_rd;
   logic          obs_wr;
   logic [AW-1:0] obs_addr;
   logic [DW-1:0] obs_rdata;
   logic [DW-1:0] obs_bus;

   function automatic int pick_winner(input logic [N-1:0] r, input int ptr);
      for (int k = 0; k < N; k++) begin
         int c;
         c = (ptr + k) % N;
         if (r[c]) return c;
      end
      return 0;
   endfunction

   // One clock: apply rst, update the model at the edge, sample at negedge,
   // and let acked requesters drop their request.
   task automatic tick(input logic do_rst);
      rst = do_rst;
      @(posedge clk);
      edge_n++;
      if ((edge_n == grant_edge + 1) && g_we) exp_mem[g_addr] = g_wdata;
      if (do_rst) begin
         grant_edge = -100;
         free_edge  = edge_n + 1;
         rr_ptr     = 0;
         exp_addr   = '0;
         exp_rdata  = '0;
      end else begin
         if ((edge_n == grant_edge + 1) && !g_we) exp_rdata = exp_mem[g_addr];
         if ((edge_n >= free_edge) && (rq.req != '0)) begin
            g_idx      = pick_winner(rq.req, rr_ptr);
            g_we       = rq.we[g_idx];
            g_addr     = rq.req_addr[g_idx];
            g_wdata    = rq.req_wdata[g_idx];
            grant_edge = edge_n;
            free_edge  = edge_n + 3;
            exp_addr   = g_addr;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            rr_ptr     = (g_idx + 1) % N;
`endif
         end
      end
      exp_rd = (edge_n == grant_edge) && g_we;
      exp_wr = (edge_n == grant_edge) && !g_we;
      if (edge_n == grant_edge + 1) exp_ack = N'(1) << g_idx;
      else exp_ack = '0;
      @(negedge clk);
      obs_ack   = rq.ack;
      obs_rd    = ram_read;
      obs_wr    = ram_write;
      obs_addr  = ram_addr;
      obs_rdata = rq.rdata;
      obs_bus   = bus;
      for (int i = 0; i < N; i++) begin
         if (obs_ack[i]) rq.req[i] = 1'b0;
      end
   endtask

   task automatic test_reset();
      rq.req = '0; rq.we = '0; rq.req_addr = '0; rq.req_wdata = '0;
      for (int i = 0; i < 3; i++) tick(1'b1);
      checks++; if (obs_ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", obs_ack); end
      checks++; if (obs_rd !== 1'b0) begin errors++; $display("FAIL reset_RAM_read: got %b want 0", obs_rd); end
      checks++; if (obs_wr !== 1'b0) begin errors++; $display("FAIL reset_RAM_write: got %b want 0", obs_wr); end
      checks++; if (obs_addr !== 10'h000) begin errors++; $display("FAIL reset_addr: got %h want 000", obs_addr); end
      checks++; if (obs_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", obs_rdata); end
      checks++; if (obs_bus !== 32'h0) begin errors++; $display("FAIL reset_bus: got %h want 0", obs_bus); end
   endtask

   task automatic test_read();
      int            wr_cycles = 0;
      int            ack_at = -1;
      logic [DW-1:0] rd_at_ack = '0;
      ram_mem[5] = 32'hDEADBEEF;
      exp_mem[5] = 32'hDEADBEEF;
      tick(1'b0);
      rq.we[0] = 1'b0; rq.req_addr[0] = 10'h005; rq.req[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick(1'b0);
         if (obs_wr) wr_cycles++;
         if (obs_ack[0] && ack_at < 0) begin ack_at = k; rd_at_ack = obs_rdata; end
         checks++; if (obs_ack[1] !== 1'b0) begin errors++; $display("FAIL read_ack1 k=%0d: got 1 want 0", k); end
      end
      checks++; if (ack_at != 1) begin errors++; $display("FAIL read_latency: ack at cycle %0d want 1", ack_at); end
      checks++; if (rd_at_ack !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata: got %h want deadbeef", rd_at_ack); end
      checks++; if (wr_cycles != 1) begin errors++; $display("FAIL read_RAM_write_len: got %0d want 1", wr_cycles); end
   endtask

   task automatic test_write_readback();
      int            ack_at = -1;
      int            rd_at = -1;
      logic [DW-1:0] bus_at_rd = '0;
      logic [DW-1:0] rd_val = '0;
      rq.we[1] = 1'b1; rq.req_addr[1] = 10'h3FF; rq.req_wdata[1] = 32'h12345678; rq.req[1] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick(1'b0);
         if (obs_ack[1] && ack_at < 0) ack_at = k;
         if (obs_rd) begin rd_at = k; bus_at_rd = obs_bus; end
         else begin
            checks++; if (obs_bus !== 32'h0) begin errors++; $display("FAIL wr_bus_idle k=%0d: got %h want 0", k, obs_bus); end
         end
      end
      checks++; if (ack_at != 1) begin errors++; $display("FAIL wr_ack: ack at cycle %0d want 1", ack_at); end
      checks++; if (rd_at != 0) begin errors++; $display("FAIL wr_RAM_read: at cycle %0d want 0", rd_at); end
      checks++; if (bus_at_rd !== 32'h12345678) begin errors++; $display("FAIL wr_bus_data: got %h want 12345678", bus_at_rd); end
      ack_at = -1;
      rq.we[0] = 1'b0; rq.req_addr[0] = 10'h3FF; rq.req[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick(1'b0);
         if (obs_ack[0] && ack_at < 0) begin ack_at = k; rd_val = obs_rdata; end
         if (!obs_rd && !obs_wr) begin
            checks++; if (obs_bus !== 32'h0) begin errors++; $display("FAIL rb_bus_idle k=%0d: got %h want 0", k, obs_bus); end
         end
      end
      checks++; if (ack_at != 1) begin errors++; $display("FAIL rb_ack: ack at cycle %0d want 1", ack_at); end
      checks++; if (rd_val !== 32'h12345678) begin errors++; $display("FAIL rb_rdata: got %h want 12345678", rd_val); end
   endtask

   task automatic test_arbitration();
      int seq [$];
      int tks [$];
      tick(1'b1);
      rq.we = 2'b00; rq.req_addr[0] = 10'h001; rq.req_addr[1] = 10'h002;
      rq.req = 2'b11;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      for (int t = 0; t < 12; t++) begin
         tick(1'b0);
         if (obs_ack != '0) begin seq.push_back(obs_ack[1] ? 1 : 0); tks.push_back(t); end
         rq.req = 2'b11;
      end
      checks++; if (seq.size() != 4) begin errors++; $display("FAIL rr_count: got %0d acks want 4", seq.size()); end
      for (int i = 0; i < seq.size() && i < 4; i++) begin
         checks++; if (seq[i] != (i % 2)) begin errors++; $display("FAIL rr_order #%0d: got %0d want %0d", i, seq[i], i % 2); end
         checks++; if (tks[i] != 1 + 3 * i) begin errors++; $display("FAIL rr_spacing #%0d: got cycle %0d want %0d", i, tks[i], 1 + 3 * i); end
      end
`else
      begin
         int n_ack1 = 0;
         int last0 = -1;
         int ack1_t = -1;
         for (int t = 0; t < 12; t++) begin
            tick(1'b0);
            if (obs_ack[0]) begin seq.push_back(0); last0 = t; end
            if (obs_ack[1]) n_ack1++;
            rq.req[0] = 1'b1;
         end
         checks++; if (seq.size() != 4) begin errors++; $display("FAIL fp_ack0_count: got %0d want 4", seq.size()); end
         checks++; if (n_ack1 != 0) begin errors++; $display("FAIL fp_starve: ack1 count %0d want 0", n_ack1); end
         for (int t = 12; t < 24 && ack1_t < 0; t++) begin
            tick(1'b0);
            if (obs_ack[0]) last0 = t;
            if (obs_ack[1]) ack1_t = t;
         end
         checks++; if (ack1_t - last0 != 3) begin errors++; $display("FAIL fp_ack1_after_drop: ack1 at %0d last ack0 %0d want gap 3", ack1_t, last0); end
      end
`endif
      rq.req = 2'b00;
      for (int t = 0; t < 3; t++) tick(1'b0);
   endtask

   task automatic test_reset_mid_access();
      int            ack_at = -1;
      logic [DW-1:0] rd_val = '0;
      rq.we[0] = 1'b0; rq.req_addr[0] = 10'h007; rq.req[0] = 1'b1;
      tick(1'b0);
      checks++; if (obs_wr !== 1'b1) begin errors++; $display("FAIL mid_access_entry: RAM_write got %b want 1", obs_wr); end
      tick(1'b1);
      checks++; if (obs_ack !== 2'b00) begin errors++; $display("FAIL mid_ack: got %b want 00", obs_ack); end
      checks++; if (obs_wr !== 1'b0 || obs_rd !== 1'b0) begin errors++; $display("FAIL mid_ctrl: got rd=%b wr=%b want 0 0", obs_rd, obs_wr); end
      checks++; if (obs_addr !== 10'h000) begin errors++; $display("FAIL mid_addr: got %h want 000", obs_addr); end
      checks++; if (obs_rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata: got %h want 0", obs_rdata); end
      checks++; if (obs_bus !== 32'h0) begin errors++; $display("FAIL mid_bus: got %h want 0", obs_bus); end
      for (int k = 0; k < 8 && ack_at < 0; k++) begin
         tick(1'b0);
         if (obs_ack[0]) begin ack_at = k; rd_val = obs_rdata; end
      end
      checks++; if (ack_at != 1) begin errors++; $display("FAIL mid_retry_ack: at cycle %0d want 1", ack_at); end
      checks++; if (rd_val !== exp_mem[7]) begin errors++; $display("FAIL mid_retry_rdata: got %h want %h", rd_val, exp_mem[7]); end
      for (int t = 0; t < 3; t++) tick(1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 800; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!rq.req[i] && $urandom_range(0, 2) == 0) begin
               rq.we[i]        = 1'($urandom_range(0, 1));
               rq.req_addr[i]  = AW'($urandom_range(0, 15));
               rq.req_wdata[i] = $urandom();
               rq.req[i]       = 1'b1;
            end
         end
         tick(1'($urandom_range(0, 149) == 0));
         checks++; if (obs_ack !== exp_ack) begin errors++; $display("FAIL rand_ack e%0d: got %b want %b", edge_n, obs_ack, exp_ack); end
         checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL rand_RAM_read e%0d: got %b want %b", edge_n, obs_rd, exp_rd); end
         checks++; if (obs_wr !== exp_wr) begin errors++; $display("FAIL rand_RAM_write e%0d: got %b want %b", edge_n, obs_wr, exp_wr); end
         checks++; if (obs_addr !== exp_addr) begin errors++; $display("FAIL rand_addr e%0d: got %h want %h", edge_n, obs_addr, exp_addr); end
         checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL rand_rdata e%0d: got %h want %h", edge_n, obs_rdata, exp_rdata); end
         checks++; if (obs_rd && obs_wr) begin errors++; $display("FAIL rand_exclusion e%0d: got rd=1 wr=1 want not both", edge_n); end
         if (!obs_rd && !obs_wr) begin
            checks++; if (obs_bus !== 32'h0) begin errors++; $display("FAIL rand_bus_idle e%0d: got %h want 0", edge_n, obs_bus); end
         end
         if (obs_rd) begin
            checks++; if (obs_bus !== g_wdata) begin errors++; $display("FAIL rand_bus_write e%0d: got %h want %h", edge_n, obs_bus, g_wdata); end
         end
      end
      rq.req = '0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ram_mem[i] = 32'(i) * 32'h9E3779B9;
         exp_mem[i] = 32'(i) * 32'h9E3779B9;
      end
      test_reset();
      test_read();
      test_write_readback();
      test_arbitration();
      test_reset_mid_access();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Sequencer and arbiter sharing the single-port 1024×32 data RAM among `N_REQ` requesters, e.g. the CPU load/store unit and the program loader. It owns the RAM's `addr`, `RAM_read` and `RAM_write` controls and is the only agent that drives the shared 32-bit data bus for RAM writes. Each requester gets a simple req/ack handshake. Every granted access runs as a fixed three-state sequence, so the RAM's combinational read path and its clocked write path are used in a fully deterministic way.

## Interface
- `N_REQ`, default 2: number of requesters, legal range 2–4.
- `ADDR_W`, default 10: RAM address width.
- `DATA_W`, default 32: data width.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  N_REQ: per-requester request level.
- `we`  in  N_REQ: 1 = write access, 0 = read access.
- `req_addr`  in  N_REQ×ADDR_W: per-requester address.
- `req_wdata`  in  N_REQ×DATA_W: per-requester write data.
- `ack`  out  N_REQ: one-hot, one-cycle completion pulse.
- `rdata`  out  DATA_W: read data, shared by all requesters, valid while `ack` is high.
- `ram_addr`  out  ADDR_W: goes to the RAM `addr` input.
- `RAM_read`  out  1: RAM latches `bus` at the clock edge (memory write).
- `RAM_write`  out  1: RAM drives `bus` (memory read).
- `bus`  inout  DATA_W (tri0): shared data bus.

## Operation
- FSM states: `IDLE`, `ACCESS`, `RESP`. All outputs are registered except the `bus` tristate.
- **IDLE**
  - If any `req` bit is high, select a winner `g`.
  - Register `req_addr[g]` into `ram_addr`, register `we[g]`, and register `req_wdata[g]` into the write buffer.
  - Next state is `ACCESS`.
  - If no `req` bit is high, stay in `IDLE`.
- **ACCESS** (exactly one cycle)
  - Write access (`we` = 1): assert `RAM_read`, and drive `bus` from the write buffer. The RAM stores the data at the closing edge.
  - Read access (`we` = 0): assert `RAM_write`, and capture `bus` into `rdata` at the closing edge.
  - Next state is `RESP`.
- **RESP**
  - `ack[g]` = 1 for this cycle only; `RAM_read` and `RAM_write` = 0.
  - Next state is `IDLE`.
- **Requester rules**
  - Hold `req`, `we`, address and data stable until `ack` is seen.
  - Drop `req` at the edge that ends the `ack` cycle. Otherwise the same request is re-served.
- **Mutual exclusion:** `RAM_read` and `RAM_write` are never both high.
- **Bus ownership:** `bus` is driven only when `RAM_read` = 1; otherwise it is `'z`. The tri0 pull-down then reads 0.
- **rdata:** holds its last captured value until the next read. Write accesses do not change it.
- **Winner selection:** see Configuration. A requester whose `req` falls while in `IDLE` is simply not served; there is no error.

## Timing
- Latency from `req` sampled in `IDLE` to `ack` is 3 cycles. Peak throughput is one access per 3 cycles; there is no back-to-back pipelining.
- Reset values: state = `IDLE`, `ack` = 0, `rdata` = 0, `ram_addr` = 0, `RAM_read` = 0, `RAM_write` = 0, `bus` = `'z`, round-robin pointer = 0.
- Reset mid-operation:
  - `rst` sampled high in `ACCESS` or `RESP` aborts the access. No `ack` is issued, and the controls are low from the next cycle.
  - If reset hits `ACCESS`, the RAM write that coincides with that reset edge still commits. This is acceptable; requesters must retry after reset.
- Simultaneous requests:
  - Only one winner per `IDLE` cycle.
  - Losers stay pending and are considered again in the next `IDLE`, i.e. at most 3 cycles later.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN`
  - **Defined:** round-robin arbitration. Search starts at the pointer; after each grant the pointer = (g+1) mod `N_REQ`. The pointer is updated only on grant.
  - **Undefined:** fixed priority; the lowest index wins and no pointer register exists. Requester 0 can starve the others by design.

## Structure
- Package `ram_arb_pkg` holds:
  - `ADDR_W`/`DATA_W` defaults.
  - `typedef enum logic [1:0] {IDLE, ACCESS, RESP} ram_arb_state_t`.
- Sub-module `ram_arb_select`: combinational winner pick.
  - Inputs: `req` and the pointer.
  - Outputs: one-hot `gnt` plus `gnt_idx`.
  - Contains both arbitration variants, selected by `RAM_ARB_ROUND_ROBIN_EN`.
- The top level holds the FSM, the registers and the tristate driver.

## Test plan
- **Read:** RAM preloaded with mem[0x005] = 0xDEADBEEF; req[0]=1, we[0]=0, addr 0x005 → `ack[0]` 3 cycles later with `rdata` = 0xDEADBEEF; `RAM_write` high for exactly 1 cycle.
- **Write then read-back:** req[1] writes 0x12345678 to 0x3FF → `ack[1]`; a later read of 0x3FF by req[0] returns 0x12345678. `bus` is `'z` in every cycle except the write's `ACCESS`.
- **Round-robin (macro defined):** req = 2'b11 held continuously, each requester dropping and re-raising after its `ack` → acks alternate 0,1,0,1, one every 3 cycles.
- **Fixed priority (macro undefined):** req = 2'b11 with req[0] re-raised immediately after each `ack` → only `ack[0]` pulses; `ack[1]` arrives on the first `IDLE` after req[0] drops.
- **Reset mid-access:** `rst` pulsed during `ACCESS` of a read → no `ack`; all outputs at reset values next cycle; the FSM serves a new request normally afterward.
- **Exclusion check:** assertion over random traffic that `RAM_read` & `RAM_write` is never 1, `ack` is one-hot or zero, and `bus` is driven only while `RAM_read` = 1.
